sm3_expnd_core: RTL and testbench

SM3 message-expansion producer feeding the compression core over the wj/wjj/vld/lst interface. It accepts one padded 512-bit block as 16 big-endian 32-bit words through a ready/valid handshake. It then streams 64 consecutive cycles of Wj and W'j = Wj ^ Wj+4 (j = 0..63), with no backpressure. It enforces the inter-block idle gap the compression core needs for its feed-forward XOR and result/reinit cycles. This is the 32-bit datapath build (SM3_INPT_DW_32).

---
 rtl/sm3_expnd_core.sv | 173 +++++++++++++++++
 tb/tb_sm3_expnd_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sm3_expnd_core.sv
// SM3 message expansion: loads one 16-word block, then streams Wj and W'j for
// 64 rounds, followed by a fixed idle gap before the next block is accepted.
module sm3_expnd_core #(
  parameter int unsigned GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pad_inpt_data_i,
  input  logic        pad_inpt_vld_i,
  input  logic        pad_inpt_lst_i,
  output logic        pad_inpt_rdy_o,
  output logic [31:0] expnd_otpt_wj_o,
  output logic [31:0] expnd_otpt_wjj_o,
  output logic        expnd_otpt_vld_o,
  output logic        expnd_otpt_lst_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 6;
  localparam int unsigned GW = 3;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXPD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [DW-1:0] win [NW];
  logic [CW-1:0] cnt;
  logic [RW-1:0] rnd;
  logic [GW-1:0] gcnt;
  logic          blk_lst;

  logic          rdy_nxt;
  logic          vld_nxt;
  logic          lst_nxt;

  logic          accept_c;
  logic          word_last_c;
  logic          rnd_last_c;
  logic          gap_last_c;
  logic [DW-1:0] wnew_c;

  function automatic logic [DW-1:0] rol7(input logic [DW-1:0] x);
    return {x[24:0], x[31:25]};
  endfunction

  function automatic logic [DW-1:0] rol15(input logic [DW-1:0] x);
    return {x[16:0], x[31:17]};
  endfunction

  function automatic logic [DW-1:0] rol23(input logic [DW-1:0] x);
    return {x[8:0], x[31:9]};
  endfunction

  function automatic logic [DW-1:0] p1(input logic [DW-1:0] x);
    return x ^ rol15(x) ^ rol23(x);
  endfunction

  assign accept_c    = (state == S_LOAD) && pad_inpt_vld_i && pad_inpt_rdy_o;
  assign word_last_c = (cnt == CW'(NW - 1));
  assign rnd_last_c  = (rnd == RW'(63));
  assign gap_last_c  = (gcnt == GW'(GAP_CYC - 1));

  // Next window word; only meaningful while expanding, harmless otherwise.
  assign wnew_c = p1(win[0] ^ win[7] ^ rol15(win[13])) ^ rol7(win[3]) ^ win[10];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    vld_nxt   = 1'b0;
    lst_nxt   = 1'b0;
    case (state)
      S_LOAD: begin
        if (accept_c && word_last_c) begin
          state_nxt = S_EXPD;
        end
      end
      S_EXPD: begin
        vld_nxt = 1'b1;
        lst_nxt = blk_lst && rnd_last_c;
        if (rnd_last_c) begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_last_c) begin
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
    rdy_nxt = (state_nxt == S_LOAD);
  end

  // Registered outputs; wj/wjj hold their last round values outside EXPD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_inpt_rdy_o   <= 1'b0;
      expnd_otpt_vld_o <= 1'b0;
      expnd_otpt_lst_o <= 1'b0;
      expnd_otpt_wj_o  <= '0;
      expnd_otpt_wjj_o <= '0;
    end else begin
      pad_inpt_rdy_o   <= rdy_nxt;
      expnd_otpt_vld_o <= vld_nxt;
      expnd_otpt_lst_o <= lst_nxt;
      if (state == S_EXPD) begin
        expnd_otpt_wj_o  <= win[0];
        expnd_otpt_wjj_o <= win[0] ^ win[4];
      end
    end
  end

  // Message window: indexed load, then shift-down with the new word at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) begin
        win[i] <= '0;
      end
    end else if (accept_c) begin
      win[cnt] <= pad_inpt_data_i;
    end else if (state == S_EXPD) begin
      for (int i = 0; i < NW - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[NW-1] <= wnew_c;
    end
  end

  // Word, round and gap counters plus the per-block last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rnd     <= '0;
      gcnt    <= '0;
      blk_lst <= 1'b0;
    end else begin
      if (accept_c) begin
        cnt <= word_last_c ? '0 : cnt + CW'(1);
        if (word_last_c) begin
          blk_lst <= pad_inpt_lst_i;
        end
      end
      if (state == S_EXPD) begin
        rnd <= rnd + RW'(1);
      end
      if (state == S_GAP) begin
        if (gap_last_c) begin
          gcnt    <= '0;
          blk_lst <= 1'b0;
        end else begin
          gcnt <= gcnt + GW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sm3_expnd_core.sv
// Directed bench for sm3_expnd_core: "abc" block, back-to-back blocks, input
// stalls, stray lst pulses and a mid-burst reset, checked against a small model.
module tb_sm3_expnd_core;

  localparam int unsigned GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        vld_i;
  logic        lst_i;
  logic        rdy;
  logic [31:0] wj;
  logic [31:0] wjj;
  logic        vld;
  logic        lst;

  int errors = 0;
  int checks = 0;

  logic [31:0] blk_words [16];
  logic [31:0] exp_w     [68];

  int   idle_run = 0;
  int   last_gap = 0;
  logic prev_vld = 1'b0;

  always #5 clk = ~clk;

  sm3_expnd_core #(.GAP_CYC(GAP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pad_inpt_data_i  (data),
    .pad_inpt_vld_i   (vld_i),
    .pad_inpt_lst_i   (lst_i),
    .pad_inpt_rdy_o   (rdy),
    .expnd_otpt_wj_o  (wj),
    .expnd_otpt_wjj_o (wjj),
    .expnd_otpt_vld_o (vld),
    .expnd_otpt_lst_o (lst)
  );

  // Length of the most recent vld-low stretch, latched when vld rises
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      if (!prev_vld) last_gap = idle_run;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_vld = (vld === 1'b1);
  end

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  task automatic build_model();
    for (int j = 0; j < 16; j++) exp_w[j] = blk_words[j];
    for (int j = 16; j < 68; j++)
      exp_w[j] = p1(exp_w[j-16] ^ exp_w[j-9] ^ rol(exp_w[j-3], 15))
                 ^ rol(exp_w[j-13], 7) ^ exp_w[j-6];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_pattern(input logic [7:0] seed);
    for (int i = 0; i < 16; i++)
      blk_words[i] = {8'(i) ^ seed, 8'hA5, 8'(i * 3) + seed, 8'h5A ^ seed};
  endtask

  // Called at a negedge; returns at the negedge right after word 15 is taken
  task automatic send_block(input logic lst15, input int lst_pulse,
                            input int stall_at, input int stall_n);
    int guard;
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          vld_i = 1'b0;
          lst_i = 1'b0;
          check("stall_rdy", 32'(rdy), 32'd1);
          @(negedge clk);
        end
      end
      guard = 0;
      while (rdy !== 1'b1 && guard < 500) begin
        vld_i = 1'b0;
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) check("rdy_timeout", 32'(rdy), 32'd1);
      data  = blk_words[i];
      vld_i = 1'b1;
      lst_i = (i == 15) ? lst15 : (i == lst_pulse);
      @(negedge clk);
    end
    vld_i = 1'b0;
    lst_i = 1'b0;
  endtask

  task automatic check_burst(input logic exp_lst, input logic abc);
    check("lat_vld_low", 32'(vld), 32'd0);
    @(negedge clk);
    for (int j = 0; j < 64; j++) begin
      check($sformatf("vld_j%0d", j), 32'(vld), 32'd1);
      check($sformatf("wj_j%0d", j), wj, exp_w[j]);
      check($sformatf("wjj_j%0d", j), wjj, exp_w[j] ^ exp_w[j+4]);
      check($sformatf("lst_j%0d", j), 32'(lst), 32'(exp_lst && (j == 63)));
      if (abc && j == 0) begin
        check("abc_wj0", wj, 32'h61626380);
        check("abc_wjj0", wjj, 32'h61626380);
      end
      if (abc && j == 11) check("abc_wjj11", wjj, 32'h00000018);
      if (abc && j == 16) check("abc_wj16", wj, 32'h9092E200);
      @(negedge clk);
    end
    check("post_vld", 32'(vld), 32'd0);
    check("post_lst", 32'(lst), 32'd0);
    check("post_wj_hold", wj, exp_w[63]);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk_words[i] = 32'h0;
    blk_words[0]  = 32'h61626380;
    blk_words[15] = 32'h00000018;
  endtask

  initial begin
    rst_n = 1'b0;
    data  = '0;
    vld_i = 1'b0;
    lst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_lst", 32'(lst), 32'd0);
    check("rst_wj", wj, 32'd0);
    check("rst_wjj", wjj, 32'd0);
    rst_n = 1'b1;
    #1 check("rel_rdy_low", 32'(rdy), 32'd0);
    @(negedge clk);
    check("rel_rdy_high", 32'(rdy), 32'd1);

    // "abc" single block
    set_abc();
    build_model();
    send_block(1'b1, -1, -1, 0);
    check_burst(1'b1, 1'b1);

    // Two-block message, upstream always valid
    set_pattern(8'h11);
    build_model();
    send_block(1'b0, -1, -1, 0);
    check_burst(1'b0, 1'b0);
    set_pattern(8'h3C);
    build_model();
    send_block(1'b1, -1, -1, 0);
    check_burst(1'b1, 1'b0);
    check("burst_gap", 32'(last_gap), 32'(GAP + 16));

    // Three stall cycles after word 7
    set_pattern(8'h11);
    build_model();
    send_block(1'b1, -1, 8, 3);
    check_burst(1'b1, 1'b0);

    // lst pulsed on word 5 only
    set_pattern(8'h77);
    build_model();
    send_block(1'b0, 5, -1, 0);
    check_burst(1'b0, 1'b0);

    // Reset while j=30 is on the outputs, then reload "abc"
    set_abc();
    build_model();
    send_block(1'b1, -1, -1, 0);
    repeat (31) @(negedge clk);
    check("pre_rst_wj30", wj, exp_w[30]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(vld), 32'd0);
    check("mid_rst_wj", wj, 32'd0);
    check("mid_rst_wjj", wjj, 32'd0);
    check("mid_rst_rdy", 32'(rdy), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_lst", 32'(lst), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_rdy", 32'(rdy), 32'd1);
    send_block(1'b1, -1, -1, 0);
    check_burst(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
